// File: rtl/l2_req_arb_pkg.sv
// Shared types and constants for the L1-to-L2 request arbiter.
// Request payload fields define the default request width.
package l2_req_arb_pkg;

    typedef logic [4:0]  L1_reqid_type;
    typedef logic [2:0]  SC_cmd_type;
    typedef logic [12:0] SC_pcsign_type;
    typedef logic [11:0] SC_poffset_type;
    typedef logic [2:0]  SC_ppaddr_type;

    localparam int L2_ARB_MAXPORTS = 8;
    localparam int L2_REQ_WIDTH    = $bits(L1_reqid_type) + $bits(SC_cmd_type) +
                                     $bits(SC_pcsign_type) + $bits(SC_poffset_type) +
                                     $bits(SC_ppaddr_type);

    localparam logic [6:0] STATS_MAX = 7'd127;

    // Saturating add for the 7-bit statistics counters.
    function automatic logic [6:0] sat_add7(input logic [6:0] a, input logic [3:0] b);
        logic [7:0] sum_s;
        sum_s = {1'b0, a} + {4'b0000, b};
        if (sum_s > {1'b0, STATS_MAX}) begin
            return STATS_MAX;
        end else begin
            return sum_s[6:0];
        end
    endfunction

endpackage

// File: rtl/l2_req_arb_fifo.sv
// Per-port request FIFO: circular buffer with naturally wrapping pointers.
// full/empty are registered so back-pressure never depends on the sender's valid.
module l2_req_fifo
    import l2_req_arb_pkg::*;
#(
    parameter int WIDTH = L2_REQ_WIDTH,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
    localparam logic [AW:0]   CNT_ZERO  = (AW+1)'(0);
    localparam logic [AW:0]   CNT_FULL  = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [AW-1:0] PTR_ZERO  = AW'(0);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    rd_ptr_r;
    logic [AW-1:0]    wr_ptr_r;
    logic [AW:0]      count_r;
    logic [AW:0]      count_nxt_s;
    logic             full_r;
    logic             empty_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign do_push_s = push && !full_r;
    assign do_pop_s  = pop && !empty_r;
    assign pop_data  = mem_r[rd_ptr_r];
    assign full      = full_r;
    assign empty     = empty_r;

    // Next occupancy; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_nxt_s = count_r;
        case ({do_push_s, do_pop_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase
    end

    // Pointer, occupancy and flag registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr_r <= PTR_ZERO;
            wr_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r <= count_nxt_s;
            full_r  <= (count_nxt_s == CNT_FULL);
            empty_r <= (count_nxt_s == CNT_ZERO);
        end
    end

    // Payload storage; contents behind the read pointer are don't-care.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

endmodule

// File: rtl/l2_req_arb.sv
// Merges NPORTS L1 request channels into one registered L2 request port
// using round-robin arbitration. Optional counters: L2_REQ_ARB_STATS_EN.
module l2_req_arb
    import l2_req_arb_pkg::*;
#(
    parameter int NPORTS = 2,
    parameter int DEPTH  = 4,
    parameter int WIDTH  = L2_REQ_WIDTH,
    parameter int PW     = $clog2(NPORTS)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NPORTS-1:0]       in_valid,
    output logic [NPORTS-1:0]       in_retry,
    input  logic [NPORTS*WIDTH-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_retry,
    output logic [WIDTH-1:0]        out_data,
    output logic [PW-1:0]           out_port
`ifdef L2_REQ_ARB_STATS_EN
    ,
    output logic [6:0]              stats_nreqs,
    output logic [6:0]              stats_nstall
`endif
);

    logic [NPORTS-1:0] push_s;
    logic [NPORTS-1:0] pop_s;
    logic [NPORTS-1:0] full_s;
    logic [NPORTS-1:0] empty_s;
    logic [WIDTH-1:0]  head_s [NPORTS];
    logic [PW-1:0]     grant_s;
    logic              grant_vld_s;
    logic              load_s;
    logic [PW-1:0]     last_grant_r;
    logic              out_valid_r;
    logic [WIDTH-1:0]  out_data_r;
    logic [PW-1:0]     out_port_r;

    assign in_retry  = full_s;
    assign push_s    = in_valid & ~full_s;
    assign load_s    = (!out_valid_r || !out_retry) && grant_vld_s;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_port  = out_port_r;

    for (genvar p = 0; p < NPORTS; p++) begin : g_fifo
        l2_req_fifo #(
            .WIDTH(WIDTH),
            .DEPTH(DEPTH)
        ) u_fifo (
            .clk      (clk),
            .reset    (reset),
            .push     (push_s[p]),
            .push_data(in_data[p*WIDTH +: WIDTH]),
            .pop      (pop_s[p]),
            .pop_data (head_s[p]),
            .full     (full_s[p]),
            .empty    (empty_s[p])
        );
    end

    // Round-robin search: first non-empty port strictly after last_grant.
    always_comb begin : rr_search
        logic [PW-1:0] cand_s;
        cand_s      = last_grant_r;
        grant_s     = last_grant_r;
        grant_vld_s = 1'b0;
        for (int off = 1; off <= NPORTS; off++) begin
            cand_s = PW'((int'(last_grant_r) + off) % NPORTS);
            if (!grant_vld_s && !empty_s[cand_s]) begin
                grant_vld_s = 1'b1;
                grant_s     = cand_s;
            end else begin
                grant_vld_s = grant_vld_s;
            end
        end
    end

    // Pop only the FIFO whose head is moving into the output stage.
    always_comb begin
        pop_s = {NPORTS{1'b0}};
        if (load_s) begin
            pop_s[grant_s] = 1'b1;
        end else begin
            pop_s = {NPORTS{1'b0}};
        end
    end

    // Output stage: load on grant, clear when drained with nothing pending, else hold.
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid_r  <= 1'b0;
            out_data_r   <= {WIDTH{1'b0}};
            out_port_r   <= {PW{1'b0}};
            last_grant_r <= PW'(NPORTS - 1);
        end else if (load_s) begin
            out_valid_r  <= 1'b1;
            out_data_r   <= head_s[grant_s];
            out_port_r   <= grant_s;
            last_grant_r <= grant_s;
        end else if (!out_valid_r || !out_retry) begin
            out_valid_r  <= 1'b0;
        end
    end

`ifdef L2_REQ_ARB_STATS_EN
    logic [6:0] nreqs_r;
    logic [6:0] nstall_r;
    logic [3:0] nacc_s;

    // Number of input transfers this cycle.
    always_comb begin
        nacc_s = 4'd0;
        for (int p = 0; p < NPORTS; p++) begin
            nacc_s = nacc_s + {3'b000, push_s[p]};
        end
    end

    // Saturating request and stall counters.
    always_ff @(posedge clk) begin
        if (!reset) begin
            nreqs_r  <= 7'd0;
            nstall_r <= 7'd0;
        end else begin
            nreqs_r  <= sat_add7(nreqs_r, nacc_s);
            nstall_r <= sat_add7(nstall_r, {3'b000, (out_valid_r && out_retry)});
        end
    end

    assign stats_nreqs  = nreqs_r;
    assign stats_nstall = nstall_r;
`endif

endmodule

// File: tb/tb_l2_req_arb.sv
// Self-checking bench for l2_req_arb (NPORTS=2, DEPTH=4, WIDTH=36) against a
// queue-based reference model; stats checks compile in with L2_REQ_ARB_STATS_EN.
`timescale 1ns/1ps
module tb_l2_req_arb;

    localparam int NP  = 2;
    localparam int DP  = 4;
    localparam int W   = 36;
    localparam int PWB = 1;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [NP-1:0]   in_valid = '0;
    logic [NP-1:0]   in_retry;
    logic [NP*W-1:0] in_data = '0;
    logic            out_valid;
    logic            out_retry = 1'b0;
    logic [W-1:0]    out_data;
    logic [PWB-1:0]  out_port;
`ifdef L2_REQ_ARB_STATS_EN
    logic [6:0]      stats_nreqs;
    logic [6:0]      stats_nstall;
`endif

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [W-1:0] mq [NP][$];
    bit           m_ov;
    logic [W-1:0] m_od;
    int           m_op;
    int           m_last;
    int           m_nreqs;
    int           m_nstall;
    bit [NP-1:0]  m_acc;

    always #5 clk = ~clk;

    l2_req_arb #(.NPORTS(NP), .DEPTH(DP), .WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_retry    (in_retry),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_retry   (out_retry),
        .out_data    (out_data),
        .out_port    (out_port)
`ifdef L2_REQ_ARB_STATS_EN
        ,
        .stats_nreqs (stats_nreqs),
        .stats_nstall(stats_nstall)
`endif
    );

    task automatic model_reset();
        for (int p = 0; p < NP; p++) mq[p].delete();
        m_ov = 1'b0; m_od = '0; m_op = 0; m_last = NP - 1;
        m_nreqs = 0; m_nstall = 0; m_acc = '0;
    endtask

    // Advance model by one clock edge using the currently driven inputs, then the DUT.
    task automatic tick();
        int  g;
        bit  found;
        int  nacc;
        if (reset == 1'b0) begin
            model_reset();
        end else begin
            for (int p = 0; p < NP; p++) m_acc[p] = in_valid[p] && (mq[p].size() < DP);
            if (m_ov && out_retry) m_nstall = (m_nstall < 127) ? m_nstall + 1 : 127;
            if (!m_ov || !out_retry) begin
                found = 0; g = 0;
                for (int off = 1; off <= NP; off++) begin
                    int c;
                    c = (m_last + off) % NP;
                    if (!found && mq[c].size() != 0) begin found = 1; g = c; end
                end
                if (found) begin
                    m_od = mq[g].pop_front(); m_op = g; m_ov = 1'b1; m_last = g;
                end else begin
                    m_ov = 1'b0;
                end
            end
            nacc = 0;
            for (int p = 0; p < NP; p++) begin
                if (m_acc[p]) begin mq[p].push_back(in_data[p*W +: W]); nacc++; end
            end
            m_nreqs = (m_nreqs + nacc > 127) ? 127 : m_nreqs + nacc;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0; in_valid = '0; out_retry = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        in_data = '1; in_valid = '0;
        reset = 1'b0;
        tick(); tick();
        reset = 1'b1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_data !== 36'h0) begin errors++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
        checks++; if (out_port !== 1'b0) begin errors++; $display("FAIL reset_out_port: got %0d expected 0", out_port); end
        checks++; if (in_retry !== 2'b00) begin errors++; $display("FAIL reset_in_retry: got %b expected 00", in_retry); end
`ifdef L2_REQ_ARB_STATS_EN
        checks++; if (stats_nreqs !== 7'd0 || stats_nstall !== 7'd0) begin errors++; $display("FAIL reset_stats: got %0d/%0d expected 0/0", stats_nreqs, stats_nstall); end
`endif
    endtask

    task automatic test_single();
        do_reset();
        in_valid = 2'b01; in_data[0 +: W] = 36'h123456789;
        tick();
        in_valid = 2'b00;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_early: got out_valid %b expected 0", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", out_valid); end
        checks++; if (out_data !== 36'h123456789) begin errors++; $display("FAIL single_data: got %h expected 123456789", out_data); end
        checks++; if (out_port !== 1'b0) begin errors++; $display("FAIL single_port: got %0d expected 0", out_port); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_drain: got %b expected 0", out_valid); end
    endtask

    task automatic test_fairness();
        int seq [NP];
        do_reset();
        for (int p = 0; p < NP; p++) seq[p] = 0;
        in_valid = 2'b11;
        for (int cyc = 0; cyc < 20; cyc++) begin
            for (int p = 0; p < NP; p++) in_data[p*W +: W] = {4'(p), 32'(seq[p])};
            tick();
            for (int p = 0; p < NP; p++) if (m_acc[p]) seq[p]++;
            if (cyc >= 1) begin
                checks++; if (out_valid !== 1'b1 || out_port !== PWB'((cyc - 1) % 2)) begin
                    errors++; $display("FAIL fair_port cyc %0d: got valid %b port %0d expected 1/%0d", cyc, out_valid, out_port, (cyc - 1) % 2); end
                checks++; if (out_data !== m_od) begin errors++; $display("FAIL fair_data cyc %0d: got %h expected %h", cyc, out_data, m_od); end
            end
        end
        in_valid = 2'b00;
    endtask

    task automatic test_full_fifo();
        do_reset();
        in_valid = 2'b01; in_data[0 +: W] = 36'hA00000000;
        tick();
        in_valid = 2'b00; out_retry = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b1 || out_port !== 1'b0) begin errors++; $display("FAIL full_preload: got %b/%0d expected 1/0", out_valid, out_port); end
        for (int i = 0; i < 4; i++) begin
            in_valid = 2'b10; in_data[W +: W] = 36'h100 + 36'(i);
            tick();
            checks++; if (in_retry[1] !== (i == 3)) begin errors++; $display("FAIL full_retry push %0d: got %b expected %b", i, in_retry[1], (i == 3)); end
        end
        in_valid = 2'b00; out_retry = 1'b0;
        tick();
        checks++; if (in_retry[1] !== 1'b0) begin errors++; $display("FAIL full_release: got %b expected 0", in_retry[1]); end
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            checks++; if (out_valid !== 1'b1 || out_port !== 1'b1 || out_data !== 36'h100 + 36'(i)) begin
                errors++; $display("FAIL full_order %0d: got %b/%0d/%h expected 1/1/%h", i, out_valid, out_port, out_data, 36'h100 + 36'(i)); end
        end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL full_drain: got %b expected 0", out_valid); end
    endtask

    task automatic test_hold();
        do_reset();
        in_valid = 2'b11; in_data[0 +: W] = 36'h0DEADBEEF; in_data[W +: W] = 36'h0CAFEF00D;
        tick();
        in_valid = 2'b00;
        tick();
        out_retry = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++; if (out_valid !== 1'b1 || out_port !== 1'b0 || out_data !== 36'h0DEADBEEF) begin
                errors++; $display("FAIL hold_%0d: got %b/%0d/%h expected 1/0/0deadbeef", k, out_valid, out_port, out_data); end
        end
`ifdef L2_REQ_ARB_STATS_EN
        checks++; if (stats_nstall !== 7'd5) begin errors++; $display("FAIL hold_nstall: got %0d expected 5", stats_nstall); end
        checks++; if (stats_nreqs !== 7'd2) begin errors++; $display("FAIL hold_nreqs: got %0d expected 2", stats_nreqs); end
`endif
        out_retry = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b1 || out_port !== 1'b1 || out_data !== 36'h0CAFEF00D) begin
            errors++; $display("FAIL hold_next: got %b/%0d/%h expected 1/1/0cafef00d", out_valid, out_port, out_data); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL hold_drain: got %b expected 0", out_valid); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        out_retry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 2'b01; in_data[0 +: W] = 36'hB00 + 36'(i);
            tick();
        end
        in_valid = 2'b00;
        checks++; if (out_valid !== 1'b1 || mq[0].size() != 3) begin errors++; $display("FAIL mid_setup: got out_valid %b buffered %0d expected 1/3", out_valid, mq[0].size()); end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid: got %b expected 0", out_valid); end
        checks++; if (in_retry !== 2'b00) begin errors++; $display("FAIL mid_in_retry: got %b expected 00", in_retry); end
        out_retry = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_stale %0d: got out_valid %b data %h expected 0", k, out_valid, out_data); end
        end
        in_valid = 2'b01; in_data[0 +: W] = 36'hC00;
        tick();
        in_valid = 2'b00;
        tick();
        checks++; if (out_valid !== 1'b1 || out_port !== 1'b0 || out_data !== 36'hC00) begin
            errors++; $display("FAIL mid_fresh: got %b/%0d/%h expected 1/0/c00", out_valid, out_port, out_data); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_after: got %b expected 0", out_valid); end
    endtask

    task automatic test_random();
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            out_retry = (cyc < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            for (int p = 0; p < NP; p++) begin
                if (!(in_valid[p] && !m_acc[p])) begin
                    in_valid[p] = ($urandom_range(0, 99) < 60);
                    in_data[p*W +: W] = {4'($urandom_range(0, 15)), 32'($urandom)};
                end
            end
            tick();
            checks++; if (out_valid !== m_ov) begin errors++; $display("FAIL rand_valid cyc %0d: got %b expected %b", cyc, out_valid, m_ov); end
            if (m_ov) begin
                checks++; if (out_data !== m_od || out_port !== PWB'(m_op)) begin
                    errors++; $display("FAIL rand_data cyc %0d: got %h/%0d expected %h/%0d", cyc, out_data, out_port, m_od, m_op); end
            end
            checks++; if (in_retry !== {mq[1].size() == DP, mq[0].size() == DP}) begin
                errors++; $display("FAIL rand_retry cyc %0d: got %b expected %b", cyc, in_retry, {mq[1].size() == DP, mq[0].size() == DP}); end
`ifdef L2_REQ_ARB_STATS_EN
            checks++; if (stats_nreqs !== 7'(m_nreqs) || stats_nstall !== 7'(m_nstall)) begin
                errors++; $display("FAIL rand_stats cyc %0d: got %0d/%0d expected %0d/%0d", cyc, stats_nreqs, stats_nstall, m_nreqs, m_nstall); end
`endif
        end
        in_valid = 2'b00;
    endtask

`ifdef L2_REQ_ARB_STATS_EN
    task automatic test_saturation();
        int total;
        do_reset();
        total = 0;
        in_valid = 2'b11;
        for (int cyc = 0; cyc < 400 && total < 200; cyc++) begin
            in_data[0 +: W] = 36'(total); in_data[W +: W] = 36'(total + 1000);
            tick();
            for (int p = 0; p < NP; p++) if (m_acc[p]) total++;
        end
        in_valid = 2'b00;
        checks++; if (total < 200) begin errors++; $display("FAIL sat_accepted: got %0d expected at least 200", total); end
        checks++; if (stats_nreqs !== 7'd127) begin errors++; $display("FAIL sat_nreqs: got %0d expected 127", stats_nreqs); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_full_fifo();
        test_hold();
        test_mid_reset();
        test_random();
`ifdef L2_REQ_ARB_STATS_EN
        test_saturation();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
